// File: rtl/rv_pkg.sv
// Shared RV32 execute-stage definitions: ALU classes,
// funct3/funct7 codes and the mul/div sequencing state.
package rv_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BR    = 3'b001;
  localparam logic [2:0] ALU_R     = 3'b010;
  localparam logic [2:0] ALU_I     = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_AUIPC = 3'b101;
  localparam logic [2:0] ALU_LINK  = 3'b110;
  localparam logic [2:0] ALU_ADD2  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } ex_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iterative multiply / restoring divide on magnitudes,
// with sign fix-up and RISC-V divide-by-zero results.
module muldiv_iter
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  logic [CW-1:0]     count;
  logic [XLEN-1:0]   hi, lo, mcand, a_raw;
  logic [2:0]        f3;
  logic              neg_q, neg_r, div0;
  logic              sgn_a, sgn_b, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, q_s, r_s;
  logic [XLEN:0]     mul_sum, rem_sh, diff;
  logic [2*XLEN-1:0] prod, prod_s;

  assign sgn_a = (funct3 != F3_MULHU) &&
                 (funct3 != F3_DIVU) &&
                 (funct3 != F3_REMU);
  assign sgn_b = sgn_a && (funct3 != F3_MULHSU);
  assign a_neg = sgn_a & op_a[XLEN-1];
  assign b_neg = sgn_b & op_b[XLEN-1];
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // hi:lo is the product for multiply, remainder:quotient for divide
  assign mul_sum = {1'b0, hi} +
                   (lo[0] ? {1'b0, mcand} : '0);
  assign rem_sh  = {hi, lo[XLEN-1]};
  assign diff    = rem_sh - {1'b0, mcand};

  assign done = busy & (count == CW'(XLEN-1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy  <= 1'b0;
      count <= '0;
      hi    <= '0;
      lo    <= '0;
      mcand <= '0;
      a_raw <= '0;
      f3    <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      count <= '0;
      hi    <= '0;
      lo    <= a_mag;
      mcand <= b_mag;
      a_raw <= op_a;
      f3    <= funct3;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      div0  <= (op_b == '0);
    end else if (busy) begin
      count <= count + 1'b1;
      if (done) busy <= 1'b0;
      if (f3[2]) begin
        if (!diff[XLEN]) begin
          hi <= diff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b1};
        end else begin
          hi <= rem_sh[XLEN-1:0];
          lo <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        {hi, lo} <= {mul_sum, lo[XLEN-1:1]};
      end
    end
  end

  assign prod   = {hi, lo};
  assign prod_s = neg_q ? -prod : prod;
  assign q_s    = neg_q ? -lo : lo;
  assign r_s    = neg_r ? -hi : hi;

  always_comb begin
    result = '0;
    unique case (f3)
      F3_MUL:    result = prod_s[XLEN-1:0];
      F3_MULH,
      F3_MULHSU,
      F3_MULHU:  result = prod_s[2*XLEN-1:XLEN];
      F3_DIV,
      F3_DIVU:   result = div0 ? '1 : q_s;
      F3_REM,
      F3_REMU:   result = div0 ? a_raw : r_s;
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: forwarding, ALU, branch resolution,
// iterative mul/div sequencing and the EX/MEM register.
module ex_stage
  import rv_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            RegWrite_in,
  input  logic            MemtoReg_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            Branch_in,
  input  logic            ALUSrc_in,
  input  logic            Jump_in,
  input  logic [2:0]      ALUOp_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic [6:0]      funct7_in,
  input  logic            wb_RegWrite,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            RegWrite_out,
  output logic            MemtoReg_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [4:0]      rd_out,
  output logic [2:0]      funct3_out,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            ex_stall
);

  localparam int SW = $clog2(XLEN);

  ex_state_e       state, state_nxt;
  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_y, sra_y;
  logic [XLEN-1:0] ex_res, md_result, pc_plus4, jalr_sum;
  logic [SW-1:0]   shamt;
  logic            ex_hit_a, ex_hit_b, wb_hit_a, wb_hit_b;
  logic            taken, is_m, m_op;
  logic            md_start, md_busy, md_done;

  // a load in EX/MEM has no data yet, so it is never a source
  assign ex_hit_a = RegWrite_out & ~MemtoReg_out &
                    (rd_out != 5'd0) & (rd_out == rs1_in);
  assign ex_hit_b = RegWrite_out & ~MemtoReg_out &
                    (rd_out != 5'd0) & (rd_out == rs2_in);
  assign wb_hit_a = wb_RegWrite & (wb_rd != 5'd0) &
                    (wb_rd == rs1_in);
  assign wb_hit_b = wb_RegWrite & (wb_rd != 5'd0) &
                    (wb_rd == rs2_in);

  always_comb begin
    fwd_a = rs1_data_in;
    if (wb_hit_a) fwd_a = wb_data;
    if (ex_hit_a) fwd_a = alu_result_out;
  end

  always_comb begin
    fwd_b = rs2_data_in;
    if (wb_hit_b) fwd_b = wb_data;
    if (ex_hit_b) fwd_b = alu_result_out;
  end

  assign op_b     = ALUSrc_in ? imm_in : fwd_b;
  assign shamt    = op_b[SW-1:0];
  assign sra_y    = $signed(fwd_a) >>> shamt;
  assign pc_plus4 = pc_in + XLEN'(4);

  always_comb begin
    alu_y = '0;
    unique case (ALUOp_in)
      ALU_ADD,
      ALU_ADD2:  alu_y = fwd_a + op_b;
      ALU_BR:    alu_y = fwd_a - op_b;
      ALU_LUI:   alu_y = imm_in;
      ALU_AUIPC: alu_y = pc_in + imm_in;
      ALU_LINK:  alu_y = pc_plus4;
      ALU_R,
      ALU_I: begin
        unique case (funct3_in)
          3'b000: alu_y = (ALUOp_in == ALU_R && funct7_in[5])
                          ? fwd_a - op_b : fwd_a + op_b;
          3'b001: alu_y = fwd_a << shamt;
          3'b010: alu_y = XLEN'($signed(fwd_a) < $signed(op_b));
          3'b011: alu_y = XLEN'(fwd_a < op_b);
          3'b100: alu_y = fwd_a ^ op_b;
          3'b101: alu_y = funct7_in[5] ? sra_y : fwd_a >> shamt;
          3'b110: alu_y = fwd_a | op_b;
          3'b111: alu_y = fwd_a & op_b;
        endcase
      end
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (funct3_in)
      F3_BEQ:  taken = (fwd_a == fwd_b);
      F3_BNE:  taken = (fwd_a != fwd_b);
      F3_BLT:  taken = ($signed(fwd_a) < $signed(fwd_b));
      F3_BGE:  taken = ($signed(fwd_a) >= $signed(fwd_b));
      F3_BLTU: taken = (fwd_a < fwd_b);
      F3_BGEU: taken = (fwd_a >= fwd_b);
      default: taken = 1'b0;
    endcase
  end

  assign jalr_sum    = fwd_a + imm_in;
  assign redirect    = reset_n & ((Branch_in & taken) | Jump_in);
  assign redirect_pc = (Jump_in & ALUSrc_in)
                       ? {jalr_sum[XLEN-1:1], 1'b0}
                       : pc_in + imm_in;
  assign flush       = redirect;

  assign is_m = (ALUOp_in == ALU_R) & (funct7_in == FUNCT7_M);
  assign m_op = is_m & MULDIV_EN;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (m_op) state_nxt = S_BUSY;
      S_BUSY:  if (md_done) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // DONE never restarts, so the held M-op retires exactly once
  always_comb begin
    md_start = (state == S_IDLE) & m_op;
    ex_stall = reset_n & (md_start | md_busy);
  end

  muldiv_iter #(.XLEN(XLEN)) u_md (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (md_start),
    .funct3  (funct3_in),
    .op_a    (fwd_a),
    .op_b    (fwd_b),
    .busy    (md_busy),
    .done    (md_done),
    .result  (md_result)
  );

  always_comb begin
    ex_res = alu_y;
    if (Jump_in)   ex_res = pc_plus4;
    else if (is_m) ex_res = MULDIV_EN ? md_result : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWrite_out   <= 1'b0;
      MemtoReg_out   <= 1'b0;
      MemRead_out    <= 1'b0;
      MemWrite_out   <= 1'b0;
      alu_result_out <= '0;
      store_data_out <= '0;
      rd_out         <= '0;
      funct3_out     <= '0;
    end else begin
      RegWrite_out   <= ~ex_stall & RegWrite_in;
      MemtoReg_out   <= ~ex_stall & MemtoReg_in;
      MemRead_out    <= ~ex_stall & MemRead_in;
      MemWrite_out   <= ~ex_stall & MemWrite_in;
      alu_result_out <= ex_stall ? '0 : ex_res;
      store_data_out <= ex_stall ? '0 : fwd_b;
      rd_out         <= ex_stall ? '0 : rd_in;
      funct3_out     <= ex_stall ? '0 : funct3_in;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed and randomized checks of ex_stage against
// an arithmetic reference model.
module tb_ex_stage;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        RegWrite_in, MemtoReg_in, MemRead_in;
  logic        MemWrite_in, Branch_in, ALUSrc_in, Jump_in;
  logic [2:0]  ALUOp_in, funct3_in;
  logic [31:0] pc_in, imm_in, rs1_data_in, rs2_data_in;
  logic [4:0]  rs1_in, rs2_in, rd_in, wb_rd;
  logic [6:0]  funct7_in;
  logic        wb_RegWrite;
  logic [31:0] wb_data;
  logic        RegWrite_out, MemtoReg_out, MemRead_out;
  logic        MemWrite_out;
  logic [31:0] alu_result_out, store_data_out, redirect_pc;
  logic [4:0]  rd_out;
  logic [2:0]  funct3_out;
  logic        redirect, flush, ex_stall;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  p_rd;
  logic        p_we, p_ld;
  logic [31:0] p_val;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(32), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .ALUSrc_in(ALUSrc_in),
    .Jump_in(Jump_in), .ALUOp_in(ALUOp_in),
    .pc_in(pc_in), .imm_in(imm_in),
    .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in),
    .funct3_in(funct3_in), .funct7_in(funct7_in),
    .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd),
    .wb_data(wb_data),
    .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
    .MemRead_out(MemRead_out), .MemWrite_out(MemWrite_out),
    .alu_result_out(alu_result_out),
    .store_data_out(store_data_out),
    .rd_out(rd_out), .funct3_out(funct3_out),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .ex_stall(ex_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_ins();
    RegWrite_in = 0; MemtoReg_in = 0; MemRead_in = 0;
    MemWrite_in = 0; Branch_in = 0; ALUSrc_in = 0;
    Jump_in = 0; ALUOp_in = 0; funct3_in = 0; funct7_in = 0;
    pc_in = 0; imm_in = 0; rs1_data_in = 0; rs2_data_in = 0;
    rs1_in = 0; rs2_in = 0; rd_in = 0;
    wb_RegWrite = 0; wb_rd = 0; wb_data = 0;
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] rs,
                                        input logic [31:0] rf);
    if (rs != 0 && p_we && !p_ld && p_rd == rs) return p_val;
    if (rs != 0 && wb_RegWrite && wb_rd == rs) return wb_data;
    return rf;
  endfunction

  function automatic logic [31:0] m_alu(
      input logic [2:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] a,
      input logic [31:0] b, input logic [31:0] pc,
      input logic [31:0] imm);
    logic signed [31:0] sa, sb;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]);
    case (op)
      3'd1: return a - b;
      3'd4: return imm;
      3'd5: return pc + imm;
      3'd6: return pc + 32'd4;
      3'd2, 3'd3: begin
        case (f3)
          3'd0: return (op == 3'd2 && f7[5]) ? a - b : a + b;
          3'd1: return a << sh;
          3'd2: return (sa < sb) ? 32'd1 : 32'd0;
          3'd3: return (a < b) ? 32'd1 : 32'd0;
          3'd4: return a ^ b;
          3'd5: begin
            if (f7[5]) begin
              sa = sa >>> sh;
              return sa;
            end
            return a >> sh;
          end
          3'd6: return a | b;
          default: return a & b;
        endcase
      end
      default: return a + b;
    endcase
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin
        pu = {32'd0, a} * {32'd0, b};
        return pu[63:32];
      end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic logic m_taken(input logic [2:0] f3,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // single-cycle instruction already on the inputs
  task automatic exec(input string tag);
    logic [31:0] a, b, ob, res, rpc;
    logic red;
    a   = m_fwd(rs1_in, rs1_data_in);
    b   = m_fwd(rs2_in, rs2_data_in);
    ob  = ALUSrc_in ? imm_in : b;
    res = Jump_in ? pc_in + 32'd4
        : m_alu(ALUOp_in, funct3_in, funct7_in, a, ob, pc_in, imm_in);
    red = (Branch_in && m_taken(funct3_in, a, b)) || Jump_in;
    rpc = (Jump_in && ALUSrc_in) ? ((a + imm_in) & ~32'd1)
                                 : pc_in + imm_in;
    #1;
    chk({tag, ".redirect"}, redirect, red);
    chk({tag, ".flush"}, flush, red);
    chk({tag, ".stall"}, ex_stall, 0);
    if (red) chk({tag, ".rpc"}, redirect_pc, rpc);
    @(posedge clk); #1;
    chk({tag, ".result"}, alu_result_out, res);
    chk({tag, ".store"}, store_data_out, b);
    chk({tag, ".rd"}, rd_out, rd_in);
    chk({tag, ".ctl"},
        {RegWrite_out, MemtoReg_out, MemRead_out, MemWrite_out},
        {RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in});
    chk({tag, ".f3"}, funct3_out, funct3_in);
    p_rd = rd_in; p_we = RegWrite_in;
    p_ld = MemtoReg_in; p_val = res;
  endtask

  task automatic exec_md(input string tag, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
    logic [31:0] exp;
    int cnt;
    idle_ins();
    ALUOp_in = ALU_R; funct7_in = FUNCT7_M; funct3_in = f3;
    rs1_in = 5'd30; rs2_in = 5'd31;
    rs1_data_in = a; rs2_data_in = b;
    rd_in = rd; RegWrite_in = 1'b1;
    exp = ref_md(f3, m_fwd(rs1_in, a), m_fwd(rs2_in, b));
    #1;
    cnt = 0;
    while (ex_stall === 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      if (cnt == 5) chk({tag, ".bubble"}, RegWrite_out, 0);
    end
    chk({tag, ".stall_cycles"}, cnt, 33);
    @(posedge clk); #1;
    chk({tag, ".result"}, alu_result_out, exp);
    chk({tag, ".we"}, RegWrite_out, 1);
    chk({tag, ".rd"}, rd_out, rd);
    p_rd = rd; p_we = 1'b1; p_ld = 1'b0; p_val = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    idle_ins();
    p_rd = 0; p_we = 0; p_ld = 0; p_val = 0;
    #1;
    chk("rst.we", RegWrite_out, 0);
    chk("rst.result", alu_result_out, 0);
    chk("rst.rd", rd_out, 0);
    chk("rst.stall", ex_stall, 0);
    chk("rst.redirect", redirect, 0);
    @(negedge clk) reset_n = 1'b1;

    // addi x1,x0,5 then add x3,x1,x2 via EX/MEM forwarding
    ALUOp_in = ALU_I; ALUSrc_in = 1; imm_in = 5;
    rd_in = 1; RegWrite_in = 1;
    exec("addi");
    idle_ins();
    ALUOp_in = ALU_R; rs1_in = 1; rs1_data_in = 32'hDEAD;
    rs2_in = 2; rs2_data_in = 7; rd_in = 3; RegWrite_in = 1;
    exec("add_fwd");
    chk("t1.add12", alu_result_out, 32'd12);

    ALUOp_in = ALU_R; rs1_in = 1; rs1_data_in = 0;
    rs2_in = 3; rs2_data_in = 0; rd_in = 3;
    wb_RegWrite = 1; wb_rd = 1; wb_data = 40;
    exec("add_wbfwd");
    chk("t1.add52", alu_result_out, 32'd52);
    rs1_in = 3; rs2_in = 0; wb_rd = 3; wb_data = 999;
    exec("add_prio");
    chk("t1.prio", alu_result_out, 32'd52);

    idle_ins();
    ALUOp_in = ALU_BR; Branch_in = 1; funct3_in = F3_BEQ;
    rs1_in = 5; rs2_in = 6; rs1_data_in = 32'h10;
    rs2_data_in = 32'h10; pc_in = 32'h100; imm_in = 32'h20;
    exec("beq");
    chk("t2.redirect", redirect, 1);
    chk("t2.rpc", redirect_pc, 32'h120);
    chk("t2.flush", flush, 1);
    funct3_in = F3_BNE;
    exec("bne");
    chk("t2.bne", redirect, 0);

    idle_ins();
    ALUOp_in = ALU_LINK; Jump_in = 1; ALUSrc_in = 1;
    rs1_in = 7; rs1_data_in = 32'h203; imm_in = 4;
    pc_in = 32'h40; rd_in = 1; RegWrite_in = 1;
    exec("jalr");
    chk("t3.rpc", redirect_pc, 32'h206);
    chk("t3.link", alu_result_out, 32'h44);
    chk("t3.we", RegWrite_out, 1);

    exec_md("mul", F3_MUL, 32'hFFFF_FFFF, 32'd3, 5'd4);
    chk("t4.mul", alu_result_out, 32'hFFFF_FFFD);
    exec_md("mulhu", F3_MULHU, 32'hFFFF_FFFF, 32'd3, 5'd4);
    chk("t4.mulhu", alu_result_out, 32'h2);
    exec_md("div0", F3_DIV, 32'd7, 32'd0, 5'd4);
    chk("t5.div0", alu_result_out, 32'hFFFF_FFFF);
    exec_md("rem0", F3_REM, 32'd7, 32'd0, 5'd4);
    chk("t5.rem0", alu_result_out, 32'd7);
    exec_md("divov", F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("t5.divov", alu_result_out, 32'h8000_0000);
    exec_md("remov", F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    chk("t5.remov", alu_result_out, 32'h0);

    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 9) begin
        exec_md("rnd_md", 3'($urandom_range(0, 7)), pick(), pick(),
                5'($urandom_range(1, 3)));
      end else begin
        idle_ins();
        ALUOp_in = 3'($urandom_range(0, 7));
        funct3_in = 3'($urandom_range(0, 7));
        funct7_in = $urandom_range(0, 1) ? 7'h20 : 7'h00;
        ALUSrc_in = 1'($urandom_range(0, 1));
        Branch_in = (ALUOp_in == ALU_BR) ? 1'($urandom_range(0, 1))
                                         : 1'b0;
        Jump_in = ($urandom_range(0, 7) == 0);
        RegWrite_in = 1'($urandom_range(0, 1));
        MemtoReg_in = ($urandom_range(0, 3) == 0);
        MemRead_in = 1'($urandom_range(0, 1));
        MemWrite_in = 1'($urandom_range(0, 1));
        rs1_in = 5'($urandom_range(0, 3));
        rs2_in = 5'($urandom_range(0, 3));
        rd_in = 5'($urandom_range(0, 3));
        rs1_data_in = pick(); rs2_data_in = pick();
        imm_in = $urandom; pc_in = $urandom & ~32'd3;
        wb_RegWrite = 1'($urandom_range(0, 1));
        wb_rd = 5'($urandom_range(0, 3));
        wb_data = $urandom;
        exec("rnd_alu");
      end
    end

    // reset in the middle of a multiply
    idle_ins();
    ALUOp_in = ALU_R; funct7_in = FUNCT7_M; funct3_in = F3_MUL;
    rs1_in = 5'd30; rs2_in = 5'd31; rs1_data_in = 32'd9;
    rs2_data_in = 32'd9; rd_in = 5'd2; RegWrite_in = 1;
    repeat (11) @(posedge clk);
    #1;
    chk("t6.busy", ex_stall, 1);
    reset_n = 1'b0;
    #1;
    chk("t6.we", RegWrite_out, 0);
    chk("t6.result", alu_result_out, 0);
    chk("t6.rd", rd_out, 0);
    chk("t6.stall", ex_stall, 0);
    chk("t6.redirect", redirect, 0);
    idle_ins();
    @(negedge clk) reset_n = 1'b1;
    p_rd = 0; p_we = 0; p_ld = 0; p_val = 0;
    @(posedge clk); #1;
    chk("t6.nopartial", RegWrite_out, 0);
    ALUOp_in = ALU_R; rs1_in = 1; rs1_data_in = 32'd20;
    rs2_in = 2; rs2_data_in = 32'd22; rd_in = 5; RegWrite_in = 1;
    exec("t6.add");
    chk("t6.add42", alu_result_out, 32'd42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
